uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// UART receiver consumer-side bundle.
// Byte delivery, status flags and the read acknowledge.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output busy,
        input  data_ack
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output data_ack
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1, oversampled by os_tick.
// Samples mid-bit and hands bytes to a single-entry output register.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      os_tick,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int W = $clog2(OVERSAMPLE);
    localparam logic [W-1:0] HALF_M1 = W'(OVERSAMPLE / 2 - 1);
    localparam logic [W-1:0] FULL_M1 = W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t       state, state_n;
    logic [W-1:0] os_cnt, os_cnt_n;
    logic [2:0]   bit_cnt, bit_cnt_n;
    logic [7:0]   shreg, shreg_n;
    logic         rx_m, rx_s, rx_p;
    logic         stop_hit;
    logic [7:0]   dout, dout_n;
    logic         dv, dv_n;
    logic         ovr, ovr_n;
    logic         ferr, ferr_n;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // Frame state, tick/bit counters and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            os_cnt  <= os_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
        end
    end

    // Next-state: edge starts a frame, everything else moves on os_tick.
    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        stop_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_p && !rx_s) begin
                    state_n  = START;
                    os_cnt_n = '0;
                end
            end
            START: begin
                if (os_tick) begin
                    if (os_cnt == HALF_M1) begin
                        os_cnt_n = '0;
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n   = DATA;
                            bit_cnt_n = '0;
                        end
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (os_tick) begin
                    if (os_cnt == FULL_M1) begin
                        shreg_n   = {rx_s, shreg[7:1]};
                        os_cnt_n  = '0;
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state_n = STOP;
                        end
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (os_tick) begin
                    if (os_cnt == FULL_M1) begin
                        stop_hit = 1'b1;
                        os_cnt_n = '0;
                        state_n  = IDLE;
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output register update: ack frees the slot before a new byte lands.
    always_comb begin
        dout_n = dout;
        dv_n   = dv;
        ovr_n  = ovr;
        ferr_n = 1'b0;
        if (bus.data_ack && dv) begin
            dv_n  = 1'b0;
            ovr_n = 1'b0;
        end
        if (stop_hit) begin
            if (rx_s) begin
                if (!dv_n) begin
                    dout_n = shreg;
                    dv_n   = 1'b1;
                end else begin
                    ovr_n = 1'b1;
                end
            end else begin
                ferr_n = 1'b1;
            end
        end
    end

    // Registered consumer-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            dv   <= 1'b0;
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            dout <= dout_n;
            dv   <= dv_n;
            ovr  <= ovr_n;
            ferr <= ferr_n;
        end
    end

    assign bus.data_out   = dout;
    assign bus.data_valid = dv;
    assign bus.overrun    = ovr;
    assign bus.frame_err  = ferr;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16.
// os_tick every 4 clk; frames start on a tick edge.
module tb_uart_rx;
    logic clk;
    logic rst;
    logic os_tick;
    logic rx;

    uart_rx_if u_if ();

    uart_rx #(
        .OVERSAMPLE(16)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .os_tick(os_tick),
        .rx     (rx),
        .bus    (u_if.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int fe_cnt      = 0;
    int fe_base;

    logic dv607, dv608;
    logic busy607, busy608;
    logic fe608, fe609;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick pulse: high for one clk out of every four.
    initial begin
        os_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 os_tick = 1'b1;
            @(posedge clk);
            #1 os_tick = 1'b0;
        end
    end

    // Count clk cycles with frame_err high.
    always @(negedge clk) begin
        if (u_if.frame_err === 1'b1) fe_cnt++;
    end

    task automatic chk8(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag,
                        input logic obs,
                        input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b",
                   tag, obs, exp);
        end
    endtask

    task automatic sync_tick();
        do @(posedge clk); while (os_tick !== 1'b1);
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 u_if.data_ack = 1'b1;
        @(posedge clk);
        #1 u_if.data_ack = 1'b0;
    endtask

    // One 640-clk frame starting on a tick edge. Stop sample
    // lands on edge 608; ack_stop raises data_ack for that edge;
    // abort pulses rst inside data bit 4.
    task automatic send_frame(input logic [7:0] d,
                              input logic sb,
                              input bit ack_stop,
                              input bit abort);
        logic [9:0] f;
        f = {sb, d, 1'b0};
        sync_tick();
        for (int c = 0; c < 640; c++) begin
            #1;
            if (c == 607) begin
                dv607   = u_if.data_valid;
                busy607 = u_if.busy;
            end
            if (c == 608) begin
                dv608   = u_if.data_valid;
                busy608 = u_if.busy;
                fe608   = u_if.frame_err;
            end
            if (c == 609) fe609 = u_if.frame_err;
            rx = f[c / 64];
            u_if.data_ack = ack_stop && (c == 607);
            if (abort && c == 340) rst = 1'b1;
            if (abort && c == 342) rst = 1'b0;
            @(posedge clk);
        end
        #1;
        rx = 1'b1;
        u_if.data_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        u_if.data_ack = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk8("rst_data_out", u_if.data_out, 8'h00);
        chk1("rst_valid", u_if.data_valid, 1'b0);
        chk1("rst_ferr", u_if.frame_err, 1'b0);
        chk1("rst_ovr", u_if.overrun, 1'b0);
        chk1("rst_busy", u_if.busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Good frame 0xA5 and its latency.
        fe_base = fe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk1("a5_dv_pre", dv607, 1'b0);
        chk1("a5_dv_post", dv608, 1'b1);
        chk1("a5_busy_pre", busy607, 1'b1);
        chk1("a5_busy_post", busy608, 1'b0);
        chk8("a5_data", u_if.data_out, 8'hA5);
        chk1("a5_valid", u_if.data_valid, 1'b1);
        chk1("a5_ovr", u_if.overrun, 1'b0);
        chk1("a5_ferr_none", fe_cnt == fe_base, 1'b1);
        ack_pulse();
        chk1("a5_ack_clr", u_if.data_valid, 1'b0);
        chk8("a5_hold", u_if.data_out, 8'hA5);

        // Start glitch: low for 3 ticks only.
        fe_base = fe_cnt;
        sync_tick();
        #1 rx = 1'b0;
        repeat (12) @(posedge clk);
        #1 rx = 1'b1;
        chk1("gl_busy_in", u_if.busy, 1'b1);
        repeat (64) @(posedge clk);
        #1;
        chk1("gl_busy_out", u_if.busy, 1'b0);
        chk1("gl_valid", u_if.data_valid, 1'b0);
        chk1("gl_ferr_none", fe_cnt == fe_base, 1'b1);

        // Bad stop bit.
        fe_base = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk1("fe_pulse", fe608, 1'b1);
        chk1("fe_after", fe609, 1'b0);
        chk1("fe_one_clk", (fe_cnt - fe_base) == 1, 1'b1);
        chk1("fe_valid", u_if.data_valid, 1'b0);
        chk8("fe_data", u_if.data_out, 8'hA5);
        chk1("fe_ovr", u_if.overrun, 1'b0);

        // Two frames without ack: overrun.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        chk8("ov_data", u_if.data_out, 8'h11);
        chk1("ov_valid", u_if.data_valid, 1'b1);
        chk1("ov_flag", u_if.overrun, 1'b1);
        ack_pulse();
        chk1("ov_ack_valid", u_if.data_valid, 1'b0);
        chk1("ov_ack_flag", u_if.overrun, 1'b0);

        // Ack with nothing pending.
        ack_pulse();
        chk1("idle_ack_valid", u_if.data_valid, 1'b0);
        chk1("idle_ack_ovr", u_if.overrun, 1'b0);
        chk8("idle_ack_data", u_if.data_out, 8'h11);

        // Ack on the stop-sample edge while overrun is set.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        chk1("same_pre_ovr", u_if.overrun, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        chk1("same_dv_edge", dv608, 1'b1);
        chk8("same_data", u_if.data_out, 8'h55);
        chk1("same_valid", u_if.data_valid, 1'b1);
        chk1("same_ovr", u_if.overrun, 1'b0);
        ack_pulse();

        // Reset mid-frame, then a clean frame.
        fe_base = fe_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        chk1("abort_valid", u_if.data_valid, 1'b0);
        chk8("abort_data", u_if.data_out, 8'h00);
        chk1("abort_busy", u_if.busy, 1'b0);
        chk1("abort_ferr_none", fe_cnt == fe_base, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        chk8("post_data", u_if.data_out, 8'h0F);
        chk1("post_valid", u_if.data_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
